// File: rtl/fb_rect_fill.sv
// Solid-colour rectangle filler for the 800x480 32bpp HPS frame buffer.
// Writes whole 64-bit words (two pixels) over Avalon-MM bursts, one burst chain per row.
module fb_rect_fill #(
  parameter logic [29:0] ADDRESS   = 30'h3800_0000,
  parameter int          WIDTH     = 800,
  parameter int          HEIGHT    = 480,
  parameter int          MAX_BURST = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [9:0]  x0,
  input  logic [9:0]  x1,
  input  logic [9:0]  y0,
  input  logic [9:0]  y1,
  input  logic [31:0] color,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [28:0] address,
  output logic [7:0]  burstcount,
  input  logic        waitrequest,
  output logic [63:0] writedata,
  output logic [7:0]  byteenable,
  output logic        write
);

  typedef enum logic [2:0] {IDLE, CHECK, SETUP, BURST, DONE} state_t;

  localparam logic [28:0] BASE_WORD  = {2'b00, ADDRESS[29:3]};
  localparam logic [9:0]  ROW_WORDS  = 10'(WIDTH / 2);
  localparam logic [10:0] WIDTH_LIM  = 11'(WIDTH);
  localparam logic [10:0] HEIGHT_LIM = 11'(HEIGHT);
  localparam logic [9:0]  BURST_MAX  = 10'(MAX_BURST);

  state_t      state;
  logic [9:0]  x0_q, x1_q, y0_q, y1_q;
  logic [31:0] color_q;
  logic [9:0]  row;
  logic [28:0] row_base;
  logic [8:0]  word_off;
  logic [9:0]  words_left;
  logic [7:0]  beat_cnt;

  // Constant multiply by the row pitch as a sum of shifted copies of y.
  function automatic logic [28:0] row_offset(input logic [9:0] y);
    logic [28:0] acc;
    acc = '0;
    for (int i = 0; i < 10; i++)
      if (ROW_WORDS[i]) acc = acc + ({19'd0, y} << i);
    return acc;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [8:0] w, input logic [9:0] lo,
                                           input logic [9:0] hi);
    logic [7:0] be;
    be = 8'hFF;
    if (w == lo[9:1] && lo[0])  be = be & 8'hF0;
    if (w == hi[9:1] && !hi[0]) be = be & 8'h0F;
    return be;
  endfunction

  function automatic logic [7:0] burst_len(input logic [9:0] left);
    return (left > BURST_MAX) ? BURST_MAX[7:0] : left[7:0];
  endfunction

  function automatic logic [9:0] row_words(input logic [9:0] lo, input logic [9:0] hi);
    return {1'b0, hi[9:1]} - {1'b0, lo[9:1]} + 10'd1;
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      address    <= '0;
      burstcount <= '0;
      writedata  <= '0;
      byteenable <= '0;
      write      <= 1'b0;
      x0_q       <= '0;
      x1_q       <= '0;
      y0_q       <= '0;
      y1_q       <= '0;
      color_q    <= '0;
      row        <= '0;
      row_base   <= '0;
      word_off   <= '0;
      words_left <= '0;
      beat_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            x0_q    <= x0;
            x1_q    <= x1;
            y0_q    <= y0;
            y1_q    <= y1;
            color_q <= color;
            busy    <= 1'b1;
            state   <= CHECK;
          end
        end
        CHECK: begin
          if (x0_q > x1_q || y0_q > y1_q ||
              {1'b0, x1_q} >= WIDTH_LIM || {1'b0, y1_q} >= HEIGHT_LIM) begin
            error <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            error      <= 1'b0;
            row        <= y0_q;
            row_base   <= BASE_WORD + row_offset(y0_q);
            word_off   <= x0_q[9:1];
            words_left <= row_words(x0_q, x1_q);
            writedata  <= {color_q, color_q};
            state      <= SETUP;
          end
        end
        SETUP: begin
          address    <= row_base + {20'd0, word_off};
          burstcount <= burst_len(words_left);
          beat_cnt   <= burst_len(words_left);
          byteenable <= lane_mask(word_off, x0_q, x1_q);
          write      <= 1'b1;
          state      <= BURST;
        end
        BURST: begin
          if (!waitrequest) begin
            word_off   <= word_off + 9'd1;
            words_left <= words_left - 10'd1;
            beat_cnt   <= beat_cnt - 8'd1;
            byteenable <= lane_mask(word_off + 9'd1, x0_q, x1_q);
            // Last beat of this burst: continue the row, step to the next row, or finish.
            if (beat_cnt == 8'd1) begin
              write <= 1'b0;
              if (words_left != 10'd1) begin
                state <= SETUP;
              end else if (row < y1_q) begin
                row        <= row + 10'd1;
                row_base   <= row_base + {19'd0, ROW_WORDS};
                word_off   <= x0_q[9:1];
                words_left <= row_words(x0_q, x1_q);
                state      <= SETUP;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= DONE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fb_rect_fill.sv
// Randomised self-checking bench for fb_rect_fill: a pixel-level model of the
// frame buffer words plus a bus monitor that records every accepted beat.
module tb_fb_rect_fill;

  localparam logic [28:0] FB_WORD   = 29'h0700_0000;
  localparam int          ROW_WORDS = 400;
  localparam int          MAXB      = 64;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        waitrequest = 1'b0;
  logic [9:0]  x0 = '0, x1 = '0, y0 = '0, y1 = '0;
  logic [31:0] color = '0;
  logic        busy, done, error, write;
  logic [28:0] address;
  logic [7:0]  burstcount, byteenable;
  logic [63:0] writedata;

  fb_rect_fill dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .x0(x0), .x1(x1), .y0(y0), .y1(y1), .color(color),
    .busy(busy), .done(done), .error(error),
    .address(address), .burstcount(burstcount), .waitrequest(waitrequest),
    .writedata(writedata), .byteenable(byteenable), .write(write)
  );

  always #10 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  bit stall_en = 1'b0;

  logic [28:0] mon_addr[$];
  logic [7:0]  mon_be[$];
  logic [63:0] mon_data[$];
  logic [28:0] bst_addr[$];
  int          bst_cnt[$];
  int          done_cnt = 0, done_cyc = -1, first_write = -1, write_cycles = 0;
  int          hold_err = 0, beat_idx = 0;
  logic        done_busy = 1'b0;

  logic [28:0] exp_addr[$];
  logic [7:0]  exp_be[$];
  logic [28:0] exp_bst_addr[$];
  int          exp_bst_cnt[$];

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  initial forever begin
    @(posedge clock);
    #1;
    waitrequest = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
  end

  // Bus monitor: sampled mid-cycle, so a beat seen here is accepted at the next edge.
  initial begin : monitor
    logic        prev_stall;
    logic [28:0] p_addr, cur_addr;
    logic [7:0]  p_cnt, p_be, cur_cnt;
    logic [63:0] p_data;
    prev_stall = 1'b0;
    p_addr = '0; cur_addr = '0; p_cnt = '0; p_be = '0; cur_cnt = '0; p_data = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_stall = 1'b0;
        beat_idx   = 0;
      end else begin
        if (prev_stall && (write !== 1'b1 || address !== p_addr || burstcount !== p_cnt ||
                           byteenable !== p_be || writedata !== p_data))
          hold_err++;
        if (write === 1'b1 && beat_idx > 0 && (address !== cur_addr || burstcount !== cur_cnt))
          hold_err++;
        if (write === 1'b1) begin
          write_cycles++;
          if (first_write < 0) first_write = cyc;
        end
        if (write === 1'b1 && waitrequest === 1'b0) begin
          if (beat_idx == 0) begin
            cur_addr = address;
            cur_cnt  = burstcount;
            bst_addr.push_back(address);
            bst_cnt.push_back(int'(burstcount));
          end
          mon_addr.push_back(address + 29'(beat_idx));
          mon_be.push_back(byteenable);
          mon_data.push_back(writedata);
          beat_idx++;
          if (beat_idx >= int'(cur_cnt)) beat_idx = 0;
        end
        if (done === 1'b1) begin
          done_cnt++;
          done_cyc  = cyc;
          done_busy = busy;
        end
        prev_stall = (write === 1'b1) && (waitrequest === 1'b1);
        p_addr = address; p_cnt = burstcount; p_be = byteenable; p_data = writedata;
      end
    end
  end

  task automatic clear_mon();
    mon_addr.delete(); mon_be.delete(); mon_data.delete();
    bst_addr.delete(); bst_cnt.delete();
    done_cnt = 0; done_cyc = -1; first_write = -1; write_cycles = 0;
    hold_err = 0; beat_idx = 0;
  endtask

  // Reference: walk every pixel, merge pixels into words, then chop each row into bursts.
  task automatic build_model(input int ax0, input int ax1, input int ay0, input int ay1);
    exp_addr.delete(); exp_be.delete(); exp_bst_addr.delete(); exp_bst_cnt.delete();
    for (int y = ay0; y <= ay1; y++) begin
      int row_first = exp_addr.size();
      int n, k;
      for (int x = ax0; x <= ax1; x++) begin
        logic [28:0] w;
        logic [7:0]  lane;
        w    = FB_WORD + 29'(y * ROW_WORDS + x / 2);
        lane = (x % 2 == 1) ? 8'hF0 : 8'h0F;
        if (exp_addr.size() > row_first && exp_addr[exp_addr.size()-1] == w)
          exp_be[exp_be.size()-1] = exp_be[exp_be.size()-1] | lane;
        else begin
          exp_addr.push_back(w);
          exp_be.push_back(lane);
        end
      end
      n = exp_addr.size() - row_first;
      k = row_first;
      while (n > 0) begin
        int c = (n > MAXB) ? MAXB : n;
        exp_bst_addr.push_back(exp_addr[k]);
        exp_bst_cnt.push_back(c);
        k += c;
        n -= c;
      end
    end
  endtask

  function automatic int beat_diffs(input logic [63:0] data, output string msg);
    int bad = 0;
    msg = "none";
    if (mon_addr.size() != exp_addr.size()) begin
      bad++;
      msg = $sformatf("beat count %0d, want %0d", mon_addr.size(), exp_addr.size());
    end
    for (int i = 0; i < mon_addr.size() && i < exp_addr.size(); i++)
      if (mon_addr[i] !== exp_addr[i] || mon_be[i] !== exp_be[i] || mon_data[i] !== data) begin
        if (bad == 0)
          msg = $sformatf("beat %0d got %h/%h/%h want %h/%h/%h", i, mon_addr[i], mon_be[i],
                          mon_data[i], exp_addr[i], exp_be[i], data);
        bad++;
      end
    return bad;
  endfunction

  function automatic int burst_diffs(output string msg);
    int bad = 0;
    msg = "none";
    if (bst_addr.size() != exp_bst_addr.size()) begin
      bad++;
      msg = $sformatf("burst count %0d, want %0d", bst_addr.size(), exp_bst_addr.size());
    end
    for (int i = 0; i < bst_addr.size() && i < exp_bst_addr.size(); i++)
      if (bst_addr[i] !== exp_bst_addr[i] || bst_cnt[i] != exp_bst_cnt[i]) begin
        if (bad == 0)
          msg = $sformatf("burst %0d got %h x%0d want %h x%0d", i, bst_addr[i], bst_cnt[i],
                          exp_bst_addr[i], exp_bst_cnt[i]);
        bad++;
      end
    return bad;
  endfunction

  task automatic issue_start(input int ax0, input int ax1, input int ay0, input int ay1,
                             input logic [31:0] col, output int c0);
    @(posedge clock); #1;
    x0 = 10'(ax0); x1 = 10'(ax1); y0 = 10'(ay0); y1 = 10'(ay1); color = col;
    start = 1'b1;
    c0 = cyc;
    @(posedge clock); #1;
    start = 1'b0;
    x0 = 10'($urandom); x1 = 10'($urandom); y0 = 10'($urandom); y1 = 10'($urandom);
    color = $urandom;
  endtask

  task automatic wait_done(input int budget, input int tail, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clock); #1;
      if (done_cnt > 0) ok = 1'b1;
    end
    repeat (tail) @(negedge clock);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #3;
    reset_n = 1'b1;
  endtask

  task automatic run_fill(input int ax0, input int ax1, input int ay0, input int ay1,
                          input logic [31:0] col, input bit stall, output int c0, output bit ok);
    clear_mon();
    build_model(ax0, ax1, ay0, ay1);
    stall_en = stall;
    issue_start(ax0, ax1, ay0, ay1, col, c0);
    wait_done(4 * (exp_addr.size() + exp_bst_addr.size()) + 40, 4, ok);
    stall_en = 1'b0;
    if (!ok) pulse_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    tests_run++;
    if ({write, address, burstcount, byteenable, writedata, busy, done, error} !== 113'd0) begin
      $display("[TB] FAIL reset_hold: outputs %h, want all zero",
               {write, address, burstcount, byteenable, writedata, busy, done, error});
      tests_failed++;
    end
    @(posedge clock); #3;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    tests_run++;
    if ({write, busy, done, error} !== 4'b0000) begin
      $display("[TB] FAIL reset_idle: write/busy/done/error %b, want 0000",
               {write, busy, done, error});
      tests_failed++;
    end
  endtask

  task automatic test_odd_edges();
    int c0; bit ok; string msg; int d;
    run_fill(3, 6, 10, 10, 32'hDEADBEEF, 1'b0, c0, ok);
    tests_run++;
    if (!ok) begin $display("[TB] FAIL odd_timeout: no done, want done"); tests_failed++; end
    tests_run++;
    if (bst_addr.size() != 1 || bst_addr[0] !== 29'h0700_0FA1 || bst_cnt[0] != 3) begin
      $display("[TB] FAIL odd_burst: %0d bursts first %h x%0d, want 1 at 07000fa1 x3",
               bst_addr.size(), bst_addr[0], bst_cnt[0]);
      tests_failed++;
    end
    tests_run++;
    if (mon_be.size() != 3 || {mon_be[0], mon_be[1], mon_be[2]} !== 24'hF0FF0F) begin
      $display("[TB] FAIL odd_be: %0d beats be %h %h %h, want f0 ff 0f",
               mon_be.size(), mon_be[0], mon_be[1], mon_be[2]);
      tests_failed++;
    end
    tests_run++;
    if (mon_data[0] !== 64'hDEADBEEF_DEADBEEF) begin
      $display("[TB] FAIL odd_data: got %h, want deadbeefdeadbeef", mon_data[0]);
      tests_failed++;
    end
    d = beat_diffs(64'hDEADBEEF_DEADBEEF, msg);
    tests_run++;
    if (d !== 0) begin $display("[TB] FAIL odd_model: %0d diffs (%s), want 0", d, msg); tests_failed++; end
    tests_run++;
    if (first_write != c0 + 3 || done_cyc != c0 + 6) begin
      $display("[TB] FAIL odd_timing: write at +%0d done at +%0d, want +3 and +6",
               first_write - c0, done_cyc - c0);
      tests_failed++;
    end
    tests_run++;
    if (done_cnt != 1 || done_busy !== 1'b0 || hold_err != 0) begin
      $display("[TB] FAIL odd_done: done_cnt %0d busy %b hold_err %0d, want 1 0 0",
               done_cnt, done_busy, hold_err);
      tests_failed++;
    end
  endtask

  task automatic test_single_pixel();
    int c0; bit ok;
    run_fill(5, 5, 0, 0, $urandom, 1'b0, c0, ok);
    tests_run++;
    if (!ok || mon_addr.size() != 1 || mon_addr[0] !== 29'h0700_0002 || mon_be[0] !== 8'hF0) begin
      $display("[TB] FAIL pixel_odd: %0d beats addr %h be %h, want 1 at 07000002 be f0",
               mon_addr.size(), mon_addr[0], mon_be[0]);
      tests_failed++;
    end
    tests_run++;
    if (done_cyc != c0 + 4) begin
      $display("[TB] FAIL pixel_timing: done at +%0d, want +4", done_cyc - c0);
      tests_failed++;
    end
    run_fill(4, 4, 0, 0, $urandom, 1'b0, c0, ok);
    tests_run++;
    if (!ok || mon_addr.size() != 1 || mon_addr[0] !== 29'h0700_0002 || mon_be[0] !== 8'h0F) begin
      $display("[TB] FAIL pixel_even: %0d beats addr %h be %h, want 1 at 07000002 be 0f",
               mon_addr.size(), mon_addr[0], mon_be[0]);
      tests_failed++;
    end
  endtask

  task automatic test_full_rows();
    int c0; bit ok; string msg; int d, n16, not_ff;
    logic [31:0] col;
    col = $urandom;
    run_fill(0, 799, 0, 2, col, 1'b0, c0, ok);
    tests_run++;
    if (!ok || bst_addr[0] !== 29'h0700_0000 || bst_cnt[0] != 64) begin
      $display("[TB] FAIL full_first: ok %b first burst %h x%0d, want 07000000 x64",
               ok, bst_addr[0], bst_cnt[0]);
      tests_failed++;
    end
    n16 = 0;
    foreach (bst_cnt[i]) if (bst_cnt[i] == 16) n16++;
    tests_run++;
    if (bst_cnt.size() != 21 || n16 != 3) begin
      $display("[TB] FAIL full_bursts: %0d bursts (%0d of 16), want 21 (3 of 16)",
               bst_cnt.size(), n16);
      tests_failed++;
    end
    not_ff = 0;
    foreach (mon_be[i]) if (mon_be[i] !== 8'hFF) not_ff++;
    tests_run++;
    if (mon_be.size() != 1200 || not_ff != 0) begin
      $display("[TB] FAIL full_be: %0d beats, %0d not ff, want 1200 and 0", mon_be.size(), not_ff);
      tests_failed++;
    end
    d = beat_diffs({col, col}, msg);
    tests_run++;
    if (d !== 0) begin $display("[TB] FAIL full_model: %0d diffs (%s), want 0", d, msg); tests_failed++; end
    tests_run++;
    if (done_cyc != c0 + 2 + 21 + 1200 || done_cnt != 1) begin
      $display("[TB] FAIL full_timing: done at +%0d count %0d, want +1223 count 1",
               done_cyc - c0, done_cnt);
      tests_failed++;
    end
    col = $urandom;
    run_fill(0, 799, 478, 479, col, 1'b0, c0, ok);
    tests_run++;
    if (!ok || mon_addr.size() == 0 || mon_addr[mon_addr.size()-1] !== 29'h0702_EDFF) begin
      $display("[TB] FAIL full_last: last beat %h, want 0702edff", mon_addr[mon_addr.size()-1]);
      tests_failed++;
    end
    d = beat_diffs({col, col}, msg) + burst_diffs(msg);
    tests_run++;
    if (d !== 0) begin $display("[TB] FAIL full_bottom: %0d diffs (%s), want 0", d, msg); tests_failed++; end
  endtask

  task automatic test_stall();
    int c0; bit ok; string msg; int d, y, badcnt;
    logic [31:0] col;
    col = $urandom;
    y = $urandom_range(0, 477);
    run_fill(1, 130, y, y + 2, col, 1'b1, c0, ok);
    tests_run++;
    if (!ok) begin $display("[TB] FAIL stall_timeout: no done, want done"); tests_failed++; end
    badcnt = 0;
    foreach (bst_cnt[i]) if (bst_cnt[i] != ((i % 2 == 0) ? 64 : 2)) badcnt++;
    tests_run++;
    if (bst_cnt.size() != 6 || badcnt != 0) begin
      $display("[TB] FAIL stall_bursts: %0d bursts, %0d wrong length, want 6 alternating 64/2",
               bst_cnt.size(), badcnt);
      tests_failed++;
    end
    tests_run++;
    if (mon_addr.size() != 198 || hold_err != 0) begin
      $display("[TB] FAIL stall_hold: %0d beats, %0d stability errors, want 198 and 0",
               mon_addr.size(), hold_err);
      tests_failed++;
    end
    d = beat_diffs({col, col}, msg) + burst_diffs(msg);
    tests_run++;
    if (d !== 0 || done_cnt != 1) begin
      $display("[TB] FAIL stall_model: %0d diffs (%s) done_cnt %0d, want 0 and 1", d, msg, done_cnt);
      tests_failed++;
    end
  endtask

  task automatic test_reject();
    int c0; bit ok; string msg; int d;
    logic [31:0] col;
    clear_mon();
    issue_start(10, 9, 0, 0, $urandom, c0);
    @(negedge clock);
    tests_run++;
    if ({busy, done} !== 2'b10) begin
      $display("[TB] FAIL reject_check: busy/done %b in check cycle, want 10", {busy, done});
      tests_failed++;
    end
    @(negedge clock);
    tests_run++;
    if ({done, error, busy} !== 3'b110) begin
      $display("[TB] FAIL reject_x: done/error/busy %b, want 110", {done, error, busy});
      tests_failed++;
    end
    repeat (4) @(negedge clock);
    tests_run++;
    if (write_cycles != 0 || done_cnt != 1 || error !== 1'b1) begin
      $display("[TB] FAIL reject_quiet: writes %0d done_cnt %0d error %b, want 0 1 1",
               write_cycles, done_cnt, error);
      tests_failed++;
    end
    clear_mon();
    issue_start(0, 9, 470, 480, $urandom, c0);
    repeat (2) @(negedge clock);
    tests_run++;
    if ({done, error, busy} !== 3'b110) begin
      $display("[TB] FAIL reject_y: done/error/busy %b, want 110", {done, error, busy});
      tests_failed++;
    end
    clear_mon();
    issue_start(790, 800, 0, 0, $urandom, c0);
    repeat (6) @(negedge clock);
    tests_run++;
    if (write_cycles != 0 || done_cnt != 1 || error !== 1'b1) begin
      $display("[TB] FAIL reject_width: writes %0d done_cnt %0d error %b, want 0 1 1",
               write_cycles, done_cnt, error);
      tests_failed++;
    end
    col = $urandom;
    run_fill(0, 1, 0, 0, col, 1'b0, c0, ok);
    d = beat_diffs({col, col}, msg);
    tests_run++;
    if (!ok || error !== 1'b0 || d != 0) begin
      $display("[TB] FAIL reject_recover: ok %b error %b diffs %0d (%s), want 1 0 0", ok, error, d, msg);
      tests_failed++;
    end
  endtask

  task automatic test_back_to_back();
    int c0, cx; bit ok; string msg; int d;
    logic [31:0] col;
    col = $urandom;
    clear_mon();
    build_model(100, 250, 7, 8);
    issue_start(100, 250, 7, 8, col, c0);
    repeat (10) @(negedge clock);
    issue_start(0, 799, 0, 479, $urandom, cx);
    wait_done(1000, 0, ok);
    d = beat_diffs({col, col}, msg) + burst_diffs(msg);
    tests_run++;
    if (!ok || d != 0 || done_cnt != 1) begin
      $display("[TB] FAIL b2b_ignore: ok %b diffs %0d (%s) done_cnt %0d, want 1 0 1",
               ok, d, msg, done_cnt);
      tests_failed++;
    end
    if (!ok) pulse_reset();
    col = $urandom;
    clear_mon();
    build_model(0, 0, 479, 479);
    issue_start(0, 0, 479, 479, col, c0);
    wait_done(100, 3, ok);
    d = beat_diffs({col, col}, msg);
    tests_run++;
    if (!ok || d != 0 || first_write != c0 + 3 || done_cyc != c0 + 4) begin
      $display("[TB] FAIL b2b_next: ok %b diffs %0d (%s) write +%0d done +%0d, want 1 0 +3 +4",
               ok, d, msg, first_write - c0, done_cyc - c0);
      tests_failed++;
    end
    if (!ok) pulse_reset();
  endtask

  task automatic test_reset_mid_burst();
    int c0; bit ok; string msg; int d;
    logic [31:0] col;
    clear_mon();
    issue_start(0, 799, 5, 5, $urandom, c0);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clock); #1;
      if (mon_addr.size() >= 5) ok = 1'b1;
    end
    #1;
    tests_run++;
    if (!ok || write !== 1'b1 || address !== FB_WORD + 29'd2000 || byteenable !== 8'hFF) begin
      $display("[TB] FAIL midreset_burst: ok %b write %b addr %h be %h, want 1 1 07000 7d0 ff",
               ok, write, address, byteenable);
      tests_failed++;
    end
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({write, address, burstcount, byteenable, writedata, busy, done, error} !== 113'd0) begin
      $display("[TB] FAIL midreset_clear: outputs %h, want all zero",
               {write, address, burstcount, byteenable, writedata, busy, done, error});
      tests_failed++;
    end
    @(posedge clock); #3;
    reset_n = 1'b1;
    col = $urandom;
    run_fill(201, 422, 300, 302, col, 1'b0, c0, ok);
    d = beat_diffs({col, col}, msg) + burst_diffs(msg);
    tests_run++;
    if (!ok || d != 0 || done_cnt != 1) begin
      $display("[TB] FAIL midreset_refill: ok %b diffs %0d (%s) done_cnt %0d, want 1 0 1",
               ok, d, msg, done_cnt);
      tests_failed++;
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 10; it++) begin
      int ax0, ax1, ay0, ay1, c0, d, hi;
      bit ok, stall;
      string msg;
      logic [31:0] col;
      ax0   = $urandom_range(0, 799);
      hi    = (ax0 + 199 > 799) ? 799 : ax0 + 199;
      ax1   = $urandom_range(ax0, hi);
      ay0   = $urandom_range(0, 479);
      ay1   = ay0 + $urandom_range(0, 2);
      if (ay1 > 479) ay1 = 479;
      stall = ($urandom_range(0, 1) == 1);
      col   = $urandom;
      run_fill(ax0, ax1, ay0, ay1, col, stall, c0, ok);
      d = beat_diffs({col, col}, msg) + burst_diffs(msg);
      tests_run++;
      if (!ok || d != 0 || hold_err != 0 || done_cnt != 1) begin
        $display("[TB] FAIL random_%0d: x %0d..%0d y %0d..%0d ok %b diffs %0d (%s) hold %0d done %0d, want 1 0 0 1",
                 it, ax0, ax1, ay0, ay1, ok, d, msg, hold_err, done_cnt);
        tests_failed++;
      end
      if (!stall) begin
        tests_run++;
        if (done_cyc != c0 + 2 + exp_bst_addr.size() + exp_addr.size()) begin
          $display("[TB] FAIL random_timing_%0d: done at +%0d, want +%0d", it, done_cyc - c0,
                   2 + exp_bst_addr.size() + exp_addr.size());
          tests_failed++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_odd_edges();
    test_single_pixel();
    test_full_rows();
    test_stall();
    test_reject();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
